// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default widths,
// FSM state encoding and requester index constants.
package alu_arb_pkg;

    localparam int DW_DEF  = 4;
    localparam int OPW_DEF = 3;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : alu_arb_pkg

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant: a lone valid requester wins, contention goes to
// the requester that was not granted last.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       gnt,
    output logic       any_valid
);

    always_comb begin
        any_valid = |req_valid;
        if (&req_valid) begin
            gnt = ~last_grant;
        end else if (req_valid[REQ1]) begin
            gnt = REQ1;
        end else begin
            gnt = REQ0;
        end
    end

endmodule : alu_arb_rr

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one
// transaction in flight. Optional grant counters under ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][DW-1:0]    req_a,
    input  logic [1:0][DW-1:0]    req_b,
    input  logic [1:0][OPW-1:0]   req_op,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_zero,
    output logic [DW-1:0]         alu_a,
    output logic [DW-1:0]         alu_b,
    output logic [OPW-1:0]        alu_op,
    input  logic [DW-1:0]         alu_result,
    input  logic                  alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]            gnt_cnt0,
    output logic [7:0]            gnt_cnt1
`endif
);

    state_t         state_q, state_d;
    logic           gnt_q;
    logic           last_grant_q;
    logic [DW-1:0]  alu_a_q, alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic [1:0]     rsp_valid_q;
    logic [DW-1:0]  rsp_data_q;
    logic           rsp_zero_q;

    logic gnt;
    logic any_valid;
    logic handshake;
    logic rsp_accept;

    alu_arb_rr u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .any_valid  (any_valid)
    );

    assign handshake  = (state_q == IDLE) && any_valid;
    assign rsp_accept = (state_q == RESP) && rsp_ready[gnt_q];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready[gi] = handshake && (gnt == 1'(gi));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= REQ0;
            last_grant_q <= REQ1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                alu_a_q      <= req_a[gnt];
                alu_b_q      <= req_b[gnt];
                alu_op_q     <= req_op[gnt];
                gnt_q        <= gnt;
                last_grant_q <= gnt;
            end
            // The ALU settles during EXEC from the registered operands.
            if (state_q == EXEC) begin
                rsp_data_q         <= alu_result;
                rsp_zero_q         <= alu_zero;
                rsp_valid_q[gnt_q] <= 1'b1;
            end
            if (rsp_accept) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [1:0][7:0] gnt_cnt_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst) begin
                gnt_cnt_q[gi] <= '0;
            end else if (req_ready[gi] && gnt_cnt_q[gi] != 8'hFF) begin
                gnt_cnt_q[gi] <= gnt_cnt_q[gi] + 8'd1;
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`endif

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on alu_*, transaction-level reference
// model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;

    localparam int DW  = 4;
    localparam int OPW = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_ready;
    logic [1:0][DW-1:0]  req_a = '0;
    logic [1:0][DW-1:0]  req_b = '0;
    logic [1:0][OPW-1:0] req_op = '0;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready = '0;
    logic [DW-1:0]       rsp_data;
    logic                rsp_zero;
    logic [DW-1:0]       alu_a, alu_b;
    logic [OPW-1:0]      alu_op;
    logic [DW-1:0]       alu_result;
    logic                alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]          gnt_cnt0, gnt_cnt1;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b,
                                             logic [OPW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is granted, its result becomes visible two
    // cycles later and stays until the owner accepts it.
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_vis = 0;
    int            m_g = 0;
    int            m_last = 1;
    logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
    logic [OPW-1:0] m_op = '0;
    int            m_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        logic [1:0] exp_rdy, exp_vld;
        int w;
        w = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
        exp_rdy = '0;
        if (!m_busy && req_valid != 0) exp_rdy[w] = 1'b1;
        exp_vld = '0;
        if (m_busy && cyc >= m_vis) exp_vld[m_g] = 1'b1;
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            if (exp_vld != 0) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_data));
                chk("rsp_zero", 32'(rsp_zero), 32'(m_data == '0));
            end
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
`ifdef ALU_ARB_STATS_EN
            chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
            chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
`endif
        end
        if (rst) begin
            m_busy = 1'b0; m_last = 1; m_a = '0; m_b = '0; m_op = '0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (m_busy) begin
            if (cyc >= m_vis && rsp_ready[m_g]) begin
                m_busy = 1'b0;
                if (chk_en) $display("txn req%0d data=%0h", m_g, m_data);
            end
        end else if (req_valid != 0) begin
            m_busy = 1'b1; m_g = w; m_last = w; m_vis = cyc + 2;
            m_a = req_a[w]; m_b = req_b[w]; m_op = req_op[w];
            m_data = alu_fn(m_a, m_b, m_op);
            if (m_cnt[w] < 255) m_cnt[w]++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int grants [$];
        bit seen;
        int gcnt;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state and single requester 0 transaction.
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        tick();
        rsp_ready = 2'b11;
        req_valid = 2'b01; req_a[0] = 4'hA; req_b[0] = 4'h8; req_op[0] = 3'b100;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_exec_valid", 32'(rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_data", 32'(rsp_data), 32'h2);
        idle(3);

        // Contention from reset alternates 0,1,0,1.
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            req_a[0] = 4'($urandom); req_a[1] = 4'($urandom);
            req_b[0] = 4'($urandom); req_b[1] = 4'($urandom);
            @(negedge clk);
            if (req_ready == 2'b01) grants.push_back(0);
            if (req_ready == 2'b10) grants.push_back(1);
            tick();
        end
        chk("alt_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("alt_grant", 32'(grants[i]), 32'(i % 2));
        idle(4);

        // Back-pressure in RESP; the other requester's rsp_ready is ignored.
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 2'b10;
        req_valid = 2'b01; req_a[0] = 4'h3; req_b[0] = 4'h5; req_op[0] = 3'd0;
        req_a[1] = 4'h1; req_b[1] = 4'h1; req_op[1] = 3'd2;
        @(negedge clk);
        chk("bp_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b11;
        tick();
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 32'h1);
        chk("bp_data", 32'(rsp_data), 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_data", 32'(rsp_data), 32'h8);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        tick();
        rsp_ready = 2'b11;
        tick();
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        tick();
        idle(6);

        // Zero result.
        req_valid = 2'b01; req_a[0] = 4'h0; req_b[0] = 4'h0; req_op[0] = 3'd0;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("zero_valid", 32'(rsp_valid), 32'h1);
        chk("zero_data", 32'(rsp_data), 32'h0);
        chk("zero_flag", 32'(rsp_zero), 32'h1);
        idle(3);

        // Reset while in EXEC discards the transaction.
        req_valid = 2'b10; req_a[1] = 4'h7; req_b[1] = 4'h2; req_op[1] = 3'd1;
        tick();
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_exec_valid", 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_exec_winner", 32'(req_ready), 32'h1);
        tick();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom_range(0, 3) | ($urandom_range(0, 3) == 0 ? 0 : 3));
            for (int k = 0; k < 2; k++) begin
                req_a[k] = 4'($urandom); req_b[k] = 4'($urandom); req_op[k] = 3'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        rsp_ready = 2'b11;
        idle(4);

        // 300 grants to requester 1.
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b10;
        gcnt = 0;
        for (int i = 0; i < 1200 && gcnt < 300; i++) begin
            req_a[1] = 4'($urandom); req_b[1] = 4'($urandom); req_op[1] = 3'($urandom);
            @(negedge clk);
            if (req_ready[1]) gcnt++;
            tick();
        end
        req_valid = '0;
        chk("stats_grants", 32'(gcnt), 32'd300);
        tick();
`ifdef ALU_ARB_STATS_EN
        @(negedge clk);
        chk("stats_cnt1", 32'(gnt_cnt1), 32'd255);
        chk("stats_cnt0", 32'(gnt_cnt0), 32'd0);
`endif
        idle(4);

        seen = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_arbiter
